// File: rtl/spi_slave_responder.sv
// Full-duplex SPI slave endpoint: receives a WIDTH-bit LSB-first word on mosi while
// returning a preloaded response word on miso, all oversampled in the clk domain.
module spi_slave_responder #(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             underrun,
    output logic             aborted
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_dly, cs_dly;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d, cnt_next;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d, tx_sel;
    logic [WIDTH-1:0]       rx_shift_q, rx_shift_d, rx_next;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic [WIDTH-1:0]       hold_data_q, hold_data_d;
    logic                   hold_full_q, hold_full_d;
    logic                   miso_q, miso_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   aborted_q, aborted_d;
    logic                   underrun_q, underrun_d;
    logic                   tx_load, frame_start;

    // cs idles high, so its synchronizer resets high to avoid a spurious frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_dly  <= 1'b0;
            cs_dly    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_dly  <= sclk_sync[SYNC_STAGES-1];
            cs_dly    <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly;
    assign sclk_fall = ~sclk_s & sclk_dly;
    assign cs_rise   = cs_s & ~cs_dly;
    assign cs_fall   = ~cs_s & cs_dly;

    assign tx_load  = tx_valid & ~hold_full_q;
    assign rx_next  = {mosi_s, rx_shift_q[WIDTH-1:1]};
    assign tx_sel   = tx_shift_q >> bit_cnt_q;
    assign cnt_next = bit_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        miso_d      = miso_q;
        rx_valid_d  = 1'b0;
        aborted_d   = 1'b0;
        underrun_d  = underrun_q;
        frame_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                // A coincident sclk rise is deliberately ignored: it is rise 0.
                if (cs_fall) begin
                    frame_start = 1'b1;
                    bit_cnt_d   = '0;
                    state_d     = StActive;
                    if (hold_full_q) begin
                        tx_shift_d = hold_data_q;
                        miso_d     = hold_data_q[0];
                    end else begin
                        tx_shift_d = '0;
                        underrun_d = 1'b1;
                    end
                end
            end
            StActive: begin
                if (cs_rise) begin
                    aborted_d = 1'b1;
                    miso_d    = 1'b0;
                    state_d   = StIdle;
                end else if (sclk_fall) begin
                    rx_shift_d = rx_next;
                    bit_cnt_d  = cnt_next;
                    if (cnt_next == CNT_W'(WIDTH)) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        miso_d     = 1'b0;
                        state_d    = StDone;
                    end
                end else if (sclk_rise && bit_cnt_q != '0) begin
                    miso_d = tx_sel[0];
                end
            end
            StDone: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            default: begin
                miso_d  = 1'b0;
                state_d = StIdle;
            end
        endcase

        // A write in the frame-start clk lands for the next frame.
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        if (tx_load) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
        end else if (frame_start) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            aborted_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            aborted_q   <= aborted_d;
            underrun_q  <= underrun_d;
        end
    end

    assign miso     = miso_q;
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != StIdle);
    assign underrun = underrun_q;
    assign aborted  = aborted_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a behavioural SPI master drives frames, a scoreboard
// queue holds expected received words and is drained by an rx_valid monitor.
module tb_spi_slave_responder;

    localparam int W    = 12;
    localparam int SYNC = 2;
    localparam int PH   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclk = 1'b0;
    logic          cs = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic [W-1:0]  tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          busy;
    logic          underrun;
    logic          aborted;

    int            vectors = 0;
    int            miscompares = 0;
    int            rv_cnt = 0;
    int            ab_cnt = 0;
    logic [W-1:0]  rx_q[$];

    spi_slave_responder #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .underrun (underrun),
        .aborted  (aborted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                rv_cnt++;
                vectors++;
                if (rx_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rx_valid: rx_data=%h, none expected", rx_data);
                end else begin
                    logic [W-1:0] exp;
                    exp = rx_q.pop_front();
                    if (rx_data !== exp) begin
                        miscompares++;
                        $display("FAIL rx_data: got %h, expected %h", rx_data, exp);
                    end
                end
            end
            if (aborted) ab_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic write_tx(input logic [W-1:0] word);
        @(negedge clk);
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_ready_before_write: got %b, expected 1", tx_ready);
        end
        tx_valid = 1'b1;
        tx_data  = word;
        @(negedge clk);
        tx_valid = 1'b0;
        vectors++;
        if (tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_ready_after_write: got %b, expected 0", tx_ready);
        end
    endtask

    // Master: cs falls with rise 0; mosi launched on rises; miso sampled at each fall.
    task automatic do_frame(input logic [W-1:0] mw, input logic [W-1:0] exp_miso,
                            input int nfalls, input bit raise_cs, input bit start_wr,
                            input logic [W-1:0] start_word, input string name);
        logic [W-1:0] got;
        got = '0;
        if (nfalls == W) rx_q.push_back(mw);
        @(negedge clk);
        cs   = 1'b0;
        sclk = 1'b1;
        mosi = mw[0];
        if (start_wr) begin
            // Hold tx_valid on the edge that processes the synced cs fall.
            repeat (SYNC) @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = start_word;
            @(negedge clk);
            tx_valid = 1'b0;
            vectors++;
            if (tx_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_start_write: tx_ready=%b busy=%b, expected tx_ready=0 busy=1",
                         name, tx_ready, busy);
            end
            repeat (PH - SYNC - 1) @(negedge clk);
        end else begin
            repeat (PH) @(negedge clk);
        end
        for (int i = 0; i < nfalls; i++) begin
            if (i > 0) begin
                sclk = 1'b1;
                mosi = mw[i];
                repeat (PH) @(negedge clk);
            end
            got[i] = miso;
            sclk = 1'b0;
            repeat (PH) @(negedge clk);
        end
        if (raise_cs) begin
            cs = 1'b1;
            repeat (PH) @(negedge clk);
        end
        if (nfalls == W) begin
            vectors++;
            if (got !== exp_miso) begin
                miscompares++;
                $display("FAIL %s_miso: got %h, expected %h", name, got, exp_miso);
            end
            vectors++;
            if (rx_q.size() != 0) begin
                miscompares++;
                $display("FAIL %s_rx_timeout: %0d words pending, expected 0", name, rx_q.size());
                rx_q.delete();
            end
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({miso, rx_valid, aborted, busy, underrun, tx_ready} !== 6'b000001 ||
            rx_data !== '0) begin
            miscompares++;
            $display("FAIL reset_values: miso=%b rv=%b ab=%b busy=%b und=%b rdy=%b rx=%h, expected 0,0,0,0,0,1,000",
                     miso, rx_valid, aborted, busy, underrun, tx_ready, rx_data);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int rv0;
        rv0 = rv_cnt;
        write_tx(12'h3E1);
        do_frame(12'hA5C, 12'h3E1, W, 1'b1, 1'b0, '0, "basic");
        vectors++;
        if (rv_cnt - rv0 != 1) begin
            miscompares++;
            $display("FAIL basic_rx_valid_count: got %0d, expected 1", rv_cnt - rv0);
        end
        check_bit("basic_underrun", underrun, 1'b0);
        check_bit("basic_tx_ready", tx_ready, 1'b1);
        check_bit("basic_busy", busy, 1'b0);
    endtask

    task automatic test_underrun();
        do_frame(12'h123, 12'h000, W, 1'b1, 1'b0, '0, "underrun");
        check_bit("underrun_set", underrun, 1'b1);
        write_tx(12'h0C3);
        do_frame(12'h0F0, 12'h0C3, W, 1'b1, 1'b0, '0, "underrun_next");
        check_bit("underrun_sticky", underrun, 1'b1);
    endtask

    task automatic test_abort();
        int rv0, ab0;
        rv0 = rv_cnt;
        ab0 = ab_cnt;
        do_frame(12'hFFF, '0, 5, 1'b1, 1'b0, '0, "abort");
        vectors++;
        if (ab_cnt - ab0 != 1 || rv_cnt - rv0 != 0) begin
            miscompares++;
            $display("FAIL abort_pulses: aborted=%0d rx_valid=%0d, expected 1 and 0",
                     ab_cnt - ab0, rv_cnt - rv0);
        end
        vectors++;
        if (rx_data !== 12'h0F0) begin
            miscompares++;
            $display("FAIL abort_rx_kept: got %h, expected 0f0", rx_data);
        end
        check_bit("abort_idle", busy, 1'b0);
        do_frame(12'h001, 12'h000, W, 1'b1, 1'b0, '0, "after_abort");
    endtask

    task automatic test_back_to_back();
        write_tx(12'h555);
        do_frame(12'hFFF, 12'h555, W, 1'b1, 1'b0, '0, "b2b_first");
        write_tx(12'hAAA);
        do_frame(12'h800, 12'hAAA, W, 1'b1, 1'b0, '0, "b2b_second");
    endtask

    task automatic test_reset_mid_frame();
        write_tx(12'h777);
        do_frame(12'h6B4, '0, 6, 1'b0, 1'b0, '0, "rst_mid");
        write_tx(12'h888);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({miso, rx_valid, aborted, busy, underrun, tx_ready} !== 6'b000001 ||
            rx_data !== '0) begin
            miscompares++;
            $display("FAIL async_reset: miso=%b rv=%b ab=%b busy=%b und=%b rdy=%b rx=%h, expected 0,0,0,0,0,1,000",
                     miso, rx_valid, aborted, busy, underrun, tx_ready, rx_data);
        end
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        write_tx(12'h246);
        do_frame(12'h9C3, 12'h246, W, 1'b1, 1'b0, '0, "after_reset");
        check_bit("after_reset_underrun", underrun, 1'b0);
    endtask

    task automatic test_write_at_start();
        do_frame(12'h3C5, 12'h000, W, 1'b1, 1'b1, 12'h5A5, "start_write");
        check_bit("start_write_underrun", underrun, 1'b1);
        check_bit("start_write_held", tx_ready, 1'b0);
        do_frame(12'h111, 12'h5A5, W, 1'b1, 1'b0, '0, "start_write_next");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_abort();
        test_back_to_back();
        test_reset_mid_frame();
        test_write_at_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
